mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction master and a
// data master.
//
// Each master has a one-entry request buffer. A small FSM grants the shared
// port to one buffered request at a time, using either round-robin or fixed
// data-first priority. The request to memory is registered. The response is
// routed back to the granted master combinationally.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   imem_in/imem_out  instruction master request / response
//   dmem_in/dmem_out  data master request / response
//   mem_in/mem_out    shared memory request (registered) / response
//
// Parameter:
//   RR_EN  1 = round-robin on ties, 0 = data port always wins ties

package mem_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  localparam int  NUM_PORTS = 2;
  localparam logic P_I = 1'b0;  // instruction port index
  localparam logic P_D = 1'b1;  // data port index

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;           // port granted most recently
  mem_in_type req_q, req_d;         // registered request to memory

  // Per-port request buffers
  logic [NUM_PORTS-1:0]       pend_q,  pend_d;
  logic [NUM_PORTS-1:0]       fence_q, fence_d;
  logic [NUM_PORTS-1:0][31:0] addr_q,  addr_d;
  logic [NUM_PORTS-1:0][31:0] wdata_q, wdata_d;
  logic [NUM_PORTS-1:0][3:0]  wstrb_q, wstrb_d;

  mem_in_type [NUM_PORTS-1:0] port_req;
  logic       [NUM_PORTS-1:0] ans;    // port is being answered this cycle
  logic       [NUM_PORTS-1:0] elig;   // pending and not just finishing

  logic decide;
  logic gnt_any;
  logic gnt_port;

  // The masters' own instr bit is implied by which port they use.
  logic unused_instr;
  assign unused_instr = imem_in.mem_instr ^ dmem_in.mem_instr;

  assign port_req[P_I] = imem_in;
  assign port_req[P_D] = dmem_in;

  assign ans[P_I] = (state_q == IBUSY) && mem_out.mem_ready;
  assign ans[P_D] = (state_q == DBUSY) && mem_out.mem_ready;

  // ---------------------------------------------------------------------
  // Request buffers. A new request is taken only when the buffer is empty
  // and the port is not being answered. A master that keeps valid high
  // through its ready cycle therefore cannot leave a stale duplicate.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_d  = pend_q;
    fence_d = fence_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (ans[p]) begin
        pend_d[p] = 1'b0;
      end else if (port_req[p].mem_valid && !pend_q[p]) begin
        pend_d[p]  = 1'b1;
        fence_d[p] = port_req[p].mem_fence;
        addr_d[p]  = port_req[p].mem_addr;
        wdata_d[p] = port_req[p].mem_wdata;
        wstrb_d[p] = port_req[p].mem_wstrb;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Arbiter FSM. A decision is made in IDLE and on the ready cycle of a
  // busy state. The port being answered is masked out, so its
  // still-set pending flag cannot win a second grant.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    req_d    = req_q;
    gnt_any  = 1'b0;
    gnt_port = P_D;
    elig     = pend_q & ~ans;
    decide   = (state_q == IDLE) || mem_out.mem_ready;

    if (elig[P_I] && elig[P_D]) begin
      gnt_any  = 1'b1;
      gnt_port = ((RR_EN != 0) && (last_q == P_D)) ? P_I : P_D;
    end else if (elig[P_I]) begin
      gnt_any  = 1'b1;
      gnt_port = P_I;
    end else if (elig[P_D]) begin
      gnt_any  = 1'b1;
      gnt_port = P_D;
    end

    if (decide) begin
      if (gnt_any) begin
        state_d         = (gnt_port == P_I) ? IBUSY : DBUSY;
        last_d          = gnt_port;
        req_d.mem_valid = 1'b1;
        req_d.mem_fence = fence_q[gnt_port];
        req_d.mem_instr = (gnt_port == P_I);
        req_d.mem_addr  = addr_q[gnt_port];
        // Instruction fetches never write.
        req_d.mem_wdata = (gnt_port == P_I) ? 32'h0 : wdata_q[gnt_port];
        req_d.mem_wstrb = (gnt_port == P_I) ? 4'h0  : wstrb_q[gnt_port];
      end else begin
        state_d = IDLE;
        req_d   = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= P_I;
      req_q   <= '0;
      pend_q  <= '0;
      fence_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      fence_q <= fence_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign mem_in = req_q;

  // Responses go straight through to the granted port only.
  always_comb begin
    imem_out.mem_ready = ans[P_I];
    imem_out.mem_rdata = ans[P_I] ? mem_out.mem_rdata : 32'h0;
    dmem_out.mem_ready = ans[P_D];
    dmem_out.mem_rdata = ans[P_D] ? mem_out.mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It runs two instances side by side on the
// same stimulus: u_rr uses round-robin and u_fp uses fixed data priority.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  mem_in_type  imem_in  = '0;
  mem_in_type  dmem_in  = '0;
  mem_out_type mem_out  = '0;

  mem_out_type imo_rr, dmo_rr, imo_fp, dmo_fp;
  mem_in_type  mi_rr, mi_fp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.RR_EN(1)) u_rr (
    .clock(clock), .reset(reset),
    .imem_in(imem_in), .imem_out(imo_rr),
    .dmem_in(dmem_in), .dmem_out(dmo_rr),
    .mem_in(mi_rr), .mem_out(mem_out)
  );

  mem_arbiter #(.RR_EN(0)) u_fp (
    .clock(clock), .reset(reset),
    .imem_in(imem_in), .imem_out(imo_fp),
    .dmem_in(dmem_in), .dmem_out(dmo_fp),
    .mem_in(mi_fp), .mem_out(mem_out)
  );

  function automatic mem_in_type mk(input logic v, input logic f, input logic ins,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [3:0] ws);
    mem_in_type r;
    r.mem_valid = v; r.mem_fence = f; r.mem_instr = ins;
    r.mem_addr = a; r.mem_wdata = wd; r.mem_wstrb = ws;
    return r;
  endfunction

  function automatic mem_out_type mo(input logic rdy, input logic [31:0] d);
    mem_out_type r;
    r.mem_ready = rdy; r.mem_rdata = d;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ready(input logic [31:0] d);
    mem_out = mo(1'b1, d);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    tick(); tick();
    chk("rst_mem_in_rr", mi_rr, '0);
    chk("rst_imem_out",  imo_rr, '0);
    chk("rst_dmem_out",  dmo_rr, '0);
    chk("rst_mem_in_fp", mi_fp, '0);
    reset = 1'b0;

    // ---------------- single instruction, held valid ----------------
    imem_in = mk(1, 0, 1, 32'h100, 32'hCAFEF00D, 4'h3);
    tick();                                   // captured, pending
    chk("i1_n1_novalid", mi_rr.mem_valid, 1'b0);
    tick();                                   // granted
    chk("i1_n2_req", mi_rr, mk(1, 0, 1, 32'h100, 0, 0));
    tick();
    chk("i1_stable1", mi_rr, mk(1, 0, 1, 32'h100, 0, 0));
    tick();
    chk("i1_stable2", mi_rr, mk(1, 0, 1, 32'h100, 0, 0));
    ready(32'hDEADBEEF);                      // valid still held here
    chk("i1_imem_rsp", imo_rr, mo(1, 32'hDEADBEEF));
    chk("i1_dmem_quiet", dmo_rr, mo(0, 0));
    tick();
    imem_in.mem_valid = 1'b0;
    mem_out = '0;
    #1;
    chk("i1_idle_req", mi_rr, '0);
    chk("i1_rsp_gone", imo_rr, mo(0, 0));
    tick();
    chk("i1_no_dup1", mi_rr.mem_valid, 1'b0);
    tick();
    chk("i1_no_dup2", mi_rr.mem_valid, 1'b0);

    // ---------------- tie with round-robin ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    dmem_in = mk(1, 0, 0, 32'h2000, 32'h11112222, 4'hF);
    imem_in = mk(1, 0, 1, 32'h100, 0, 0);
    tick();
    dmem_in.mem_valid = 1'b0;
    imem_in.mem_valid = 1'b0;
    tick();
    chk("tie1_data_first", mi_rr, mk(1, 0, 0, 32'h2000, 32'h11112222, 4'hF));
    ready(32'hAAAA0001);
    chk("tie1_dmem_rsp", dmo_rr, mo(1, 32'hAAAA0001));
    chk("tie1_imem_quiet", imo_rr, mo(0, 0));
    tick();
    mem_out = '0; #1;
    chk("tie1_instr_b2b", mi_rr, mk(1, 0, 1, 32'h100, 0, 0));
    ready(32'hBBBB0002);
    chk("tie1_imem_rsp", imo_rr, mo(1, 32'hBBBB0002));
    chk("tie1_dmem_quiet", dmo_rr, mo(0, 0));
    tick();
    mem_out = '0; #1;
    chk("tie1_idle", mi_rr, '0);

    // data-only transfer leaves the pointer on data
    dmem_in = mk(1, 1, 0, 32'h3000, 32'h5, 4'h1);
    tick();
    dmem_in.mem_valid = 1'b0;
    tick();
    chk("d_only_fence", mi_rr, mk(1, 1, 0, 32'h3000, 32'h5, 4'h1));
    ready(32'h0);
    tick();
    mem_out = '0; #1;

    // next tie goes to the instruction port
    dmem_in = mk(1, 0, 0, 32'h4000, 32'h44, 4'h2);
    imem_in = mk(1, 0, 1, 32'h200, 0, 0);
    tick();
    dmem_in.mem_valid = 1'b0;
    imem_in.mem_valid = 1'b0;
    tick();
    chk("tie2_instr_first", mi_rr, mk(1, 0, 1, 32'h200, 0, 0));
    ready(32'hC0DE0003);
    chk("tie2_imem_rsp", imo_rr, mo(1, 32'hC0DE0003));
    tick();
    mem_out = '0; #1;
    chk("tie2_data_b2b", mi_rr, mk(1, 0, 0, 32'h4000, 32'h44, 4'h2));
    ready(32'h0);
    tick();
    mem_out = '0; #1;
    chk("tie2_idle", mi_rr, '0);

    // ---------------- three ties, fixed priority ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dmem_in = mk(1, 0, 0, 32'h5000 + 32'(k * 16), 32'hA0 + 32'(k), 4'hC);
      imem_in = mk(1, 0, 1, 32'h600 + 32'(k * 4), 0, 0);
      tick();
      dmem_in.mem_valid = 1'b0;
      imem_in.mem_valid = 1'b0;
      tick();
      chk("fp_tie_data", mi_fp, mk(1, 0, 0, 32'h5000 + 32'(k * 16), 32'hA0 + 32'(k), 4'hC));
      ready(32'h900 + 32'(k));
      chk("fp_tie_dmem_rsp", dmo_fp, mo(1, 32'h900 + 32'(k)));
      tick();
      mem_out = '0; #1;
      chk("fp_tie_instr", mi_fp, mk(1, 0, 1, 32'h600 + 32'(k * 4), 0, 0));
      ready(32'h0);
      tick();
      mem_out = '0; #1;
    end
    chk("fp_idle", mi_fp, '0);

    // ---------------- reset in DBUSY ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    dmem_in = mk(1, 0, 0, 32'h6000, 32'h66, 4'hF);
    tick();
    dmem_in.mem_valid = 1'b0;
    tick();
    chk("rmid_dbusy", mi_rr.mem_valid, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    ready(32'h77);
    chk("rmid_dmem_quiet", dmo_rr, mo(0, 0));
    chk("rmid_imem_quiet", imo_rr, mo(0, 0));
    chk("rmid_no_req", mi_rr, '0);
    tick();
    mem_out = '0; #1;
    chk("rmid_still_idle", mi_rr, '0);
    // a new request sees normal latency from IDLE
    imem_in = mk(1, 0, 1, 32'h700, 0, 0);
    tick();
    imem_in.mem_valid = 1'b0;
    chk("rmid_new_n1", mi_rr.mem_valid, 1'b0);
    tick();
    chk("rmid_new_n2", mi_rr, mk(1, 0, 1, 32'h700, 0, 0));
    ready(32'h1);
    tick();
    mem_out = '0; #1;

    // ---------------- stray ready in IDLE ----------------
    ready(32'h12345678);
    chk("stray_imem", imo_rr, mo(0, 0));
    chk("stray_dmem", dmo_rr, mo(0, 0));
    chk("stray_imem_fp", imo_fp, mo(0, 0));
    chk("stray_dmem_fp", dmo_fp, mo(0, 0));
    tick();
    mem_out = '0; #1;
    chk("stray_no_req", mi_rr, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
